// File: rtl/axis_rx_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rx_arbiter
//
// Merges two AXI-Stream sources into one output stream with packet-granular
// round-robin arbitration. A source that wins the grant keeps it until its
// tlast beat is accepted. Every packet costs one IDLE arbitration cycle. The
// output is a single registered stage (one cycle of latency), and back-pressure
// is applied to the granted source only.
//
// Parameters
//   DW : stream data width in bits (a multiple of 8)
//   CW : width of the per-source packet counters
//
// Ports
//   clk, reset                    : clock and synchronous active-high reset
//   axis_rx1_* / axis_rx2_*       : source streams (tdata, tkeep, tlast, tvalid in; tready out)
//   axis_tx_*                     : merged stream (tdata, tkeep, tlast, tvalid, tuser out; tready in)
//                                   tuser = source ID of the beat (0 = rx1, 1 = rx2)
//   pkt_cnt1, pkt_cnt2            : packets forwarded from rx1 / rx2 (wrap modulo 2^CW)
//   busy                          : high while a source holds the grant
// -----------------------------------------------------------------------------
module axis_rx_arbiter #(
    parameter int DW = 128,
    parameter int CW = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [DW-1:0]     axis_rx1_tdata,
    input  logic [DW/8-1:0]   axis_rx1_tkeep,
    input  logic              axis_rx1_tlast,
    input  logic              axis_rx1_tvalid,
    output logic              axis_rx1_tready,

    input  logic [DW-1:0]     axis_rx2_tdata,
    input  logic [DW/8-1:0]   axis_rx2_tkeep,
    input  logic              axis_rx2_tlast,
    input  logic              axis_rx2_tvalid,
    output logic              axis_rx2_tready,

    output logic [DW-1:0]     axis_tx_tdata,
    output logic [DW/8-1:0]   axis_tx_tkeep,
    output logic              axis_tx_tlast,
    output logic              axis_tx_tvalid,
    input  logic              axis_tx_tready,
    output logic              axis_tx_tuser,

    output logic [CW-1:0]     pkt_cnt1,
    output logic [CW-1:0]     pkt_cnt2,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT1 = 2'd1,
        GRANT2 = 2'd2
    } state_t;

    state_t state_reg, state_next;
    logic   rr_reg, rr_next;        // 0: rx1 wins a tie, 1: rx2 wins a tie

    logic              tx_valid_reg;
    logic [DW-1:0]     tx_data_reg;
    logic [DW/8-1:0]   tx_keep_reg;
    logic              tx_last_reg;
    logic              tx_user_reg;

    // Per-source vectors, index 0 = rx1, index 1 = rx2.
    logic [1:0] src_valid;
    logic [1:0] src_last;
    logic [1:0] src_grant;
    logic [1:0] src_ready;
    logic [1:0] src_acc;

    assign src_valid = {axis_rx2_tvalid, axis_rx1_tvalid};
    assign src_last  = {axis_rx2_tlast,  axis_rx1_tlast};
    assign src_grant = {state_reg == GRANT2, state_reg == GRANT1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic [CW-1:0] cnt_reg;

            // Ready is gated by reset so no beat can slip in while the
            // registered grant still reflects pre-reset state.
            assign src_ready[gi] = src_grant[gi] & ~reset & (~tx_valid_reg | axis_tx_tready);
            assign src_acc[gi]   = src_ready[gi] & src_valid[gi];

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (src_acc[gi] && src_last[gi]) begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end
        end
    endgenerate

    assign axis_rx1_tready = src_ready[0];
    assign axis_rx2_tready = src_ready[1];
    assign pkt_cnt1        = g_src[0].cnt_reg;
    assign pkt_cnt2        = g_src[1].cnt_reg;
    assign busy            = (state_reg != IDLE);

    // State and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            rr_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            rr_reg    <= rr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rr_next    = rr_reg;
        case (state_reg)
            IDLE: begin
                if (src_valid[0] && src_valid[1]) begin
                    state_next = rr_reg ? GRANT2 : GRANT1;
                end else if (src_valid[0]) begin
                    state_next = GRANT1;
                end else if (src_valid[1]) begin
                    state_next = GRANT2;
                end
            end
            GRANT1: begin
                if (src_acc[0] && src_last[0]) begin
                    state_next = IDLE;
                    rr_next    = 1'b1;
                end
            end
            GRANT2: begin
                if (src_acc[1] && src_last[1]) begin
                    state_next = IDLE;
                    rr_next    = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output stage. Upstream ready already guarantees the register is empty
    // or draining whenever a new beat is accepted, so loading is always safe.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= '0;
            tx_keep_reg  <= '0;
            tx_last_reg  <= 1'b0;
            tx_user_reg  <= 1'b0;
        end else if (|src_acc) begin
            tx_valid_reg <= 1'b1;
            tx_data_reg  <= src_acc[1] ? axis_rx2_tdata : axis_rx1_tdata;
            tx_keep_reg  <= src_acc[1] ? axis_rx2_tkeep : axis_rx1_tkeep;
            tx_last_reg  <= src_acc[1] ? axis_rx2_tlast : axis_rx1_tlast;
            tx_user_reg  <= src_acc[1];
        end else if (axis_tx_tready) begin
            tx_valid_reg <= 1'b0;
        end
    end

    assign axis_tx_tvalid = tx_valid_reg;
    assign axis_tx_tdata  = tx_data_reg;
    assign axis_tx_tkeep  = tx_keep_reg;
    assign axis_tx_tlast  = tx_last_reg;
    assign axis_tx_tuser  = tx_user_reg;

endmodule

// File: doc/axis_rx_arbiter.md
AXIS_RX_ARBITER -- requirements
Module: axis_rx_arbiter

Interface
REQ-001 Parameter DW, default 128, SHALL set the stream data width in bits; DW SHALL be a multiple of 8.
REQ-002 Parameter CW, default 16, SHALL set the per-source packet counter width.
REQ-003 clk  input  1  SHALL be the single clock; all logic is clocked on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 axis_rx1_tdata/tkeep/tlast/tvalid  input  DW/DW/8/1/1  SHALL be source-1 AXI-Stream inputs.
REQ-006 axis_rx1_tready  output  1  SHALL be the source-1 ready signal.
REQ-007 axis_rx2_tdata/tkeep/tlast/tvalid  input  DW/DW/8/1/1  SHALL be source-2 AXI-Stream inputs.
REQ-008 axis_rx2_tready  output  1  SHALL be the source-2 ready signal.
REQ-009 axis_tx_tdata/tkeep/tlast/tvalid  output  DW/DW/8/1/1  SHALL be the merged output stream.
REQ-010 axis_tx_tready  input  1  SHALL be the downstream ready signal.
REQ-011 axis_tx_tuser  output  1  SHALL carry the source ID (0 = rx1, 1 = rx2) of the current output beat.
REQ-012 pkt_cnt1, pkt_cnt2  output  CW  SHALL count packets forwarded from rx1 and rx2 respectively.
REQ-013 busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, GRANT1 and GRANT2.
REQ-015 In IDLE with only rx1 tvalid high, the next state SHALL be GRANT1; with only rx2 tvalid high, the next state SHALL be GRANT2.
REQ-016 In IDLE with both tvalid signals high, the grant SHALL go to the source not served last (round-robin pointer rr): rr=0 selects rx1 and rr=1 selects rx2.
REQ-017 In IDLE, no beat SHALL be accepted: both tready outputs SHALL be 0.
REQ-018 Arbitration SHALL be packet-granular: once granted, a source SHALL keep the grant until its tlast beat is accepted, whatever the other source does.
REQ-019 The granted source's tready SHALL equal (~axis_tx_tvalid | axis_tx_tready), combinational from registered state and the downstream ready; the ungranted source's tready SHALL be 0.
REQ-020 A beat SHALL be accepted when the granted source has tvalid & tready; its data, tkeep, tlast and source ID SHALL be registered into the output stage on that edge.
REQ-021 Latency from source acceptance to axis_tx_tvalid SHALL be 1 cycle.
REQ-022 At full throughput, one beat per cycle SHALL pass with no bubbles inside a packet.
REQ-023 Once axis_tx_tvalid is high, the output stage SHALL hold tdata, tkeep, tlast and tuser stable until axis_tx_tready is high.
REQ-024 When output and input transfers occur in the same cycle, the output register SHALL load the new beat and stay valid.
REQ-025 When only an output transfer occurs, axis_tx_tvalid SHALL drop to 0.
REQ-026 On acceptance of a tlast beat, the FSM SHALL return to IDLE and rr SHALL point to the other source.
REQ-027 On acceptance of a tlast beat, the matching pkt_cnt SHALL increment by 1 and wrap modulo 2^CW with no saturation.
REQ-028 A single-beat packet (tlast on the first beat) SHALL be handled as GRANTx → IDLE after one acceptance.
REQ-029 Each packet SHALL incur one IDLE arbitration cycle, so back-to-back packets have a 1-cycle input gap.
REQ-030 tkeep SHALL be passed through unmodified; a beat with tkeep all-zero SHALL still be forwarded.

Reset
REQ-031 While reset is high at a clock edge, the state SHALL be IDLE, rr=0, axis_tx_tvalid=0, axis_tx_tlast=0, axis_tx_tuser=0, axis_tx_tdata=0, axis_tx_tkeep=0, pkt_cnt1=0, pkt_cnt2=0 and busy=0.
REQ-032 Reset asserted mid-packet SHALL discard the in-flight output beat and grant; after reset, the next arbitration SHALL start fresh without awaiting tlast.
REQ-033 Both tready outputs SHALL be 0 during reset and in the first cycle after reset deasserts.

Verification
REQ-034 The bench SHALL cover: rx1 sends a 4-beat packet with tx_tready=1 -> 4 output beats with tuser=0 on consecutive cycles starting 1 cycle after the first acceptance, tlast on beat 4, and pkt_cnt1=1.
REQ-035 The bench SHALL cover: rx1 and rx2 both valid from reset with 2-beat packets -> output order rx1 packet then rx2 packet, no interleaving, pkt_cnt1=1 and pkt_cnt2=1.
REQ-036 The bench SHALL cover: rx2 raises tvalid mid rx1 packet -> rx2_tready stays 0 until rx1 tlast is accepted, and the next grant goes to rx2.
REQ-037 The bench SHALL cover: tx_tready held 0 for 5 cycles mid-packet -> output beat stable, granted tready=0, no data loss, and the stream resumes in order.
REQ-038 The bench SHALL cover: 65536 single-beat rx1 packets with CW=16 -> pkt_cnt1 wraps to 0.
REQ-039 The bench SHALL cover: reset pulsed for 1 cycle during beat 2 of a 4-beat packet -> tx_tvalid=0 the next cycle, state IDLE, counters 0, and a new packet is forwarded correctly afterwards.
